// File: rtl/dfb_spi_pkg.sv
// dfb_spi_pkg: shared state encoding, register map and STATUS bit layout
// for the DFB SPI sequencer.
package dfb_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LO,
    S_HI,
    S_DONE
  } spi_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_BUSY    = 7;
  localparam int ST_TXFULL  = 6;
  localparam int ST_TXEMPTY = 5;
  localparam int ST_RXFULL  = 4;
  localparam int ST_RXEMPTY = 3;
  localparam int ST_TXOVF   = 2;
  localparam int ST_RXOVF   = 1;
  localparam int ST_CS      = 0;

endpackage

// File: rtl/dfb_sync_fifo.sv
// dfb_sync_fifo: 8-bit first-word-fall-through FIFO, power-of-two depth.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module dfb_sync_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       CLKOSC,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge CLKOSC) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dfb_spi_sequencer.sv
// dfb_spi_sequencer: Mode 0 SPI master with TX/RX FIFOs and a CPU register port.
// DFB_SPI_AUTOCS_EN: chip select follows the shift engine instead of CTRL[0].
module dfb_spi_sequencer
  import dfb_spi_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RESET  = 8'd49
) (
  input  logic       CLKOSC,
  input  logic       RST,
  input  logic [1:0] reg_sel,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs,
  output logic       busy
);

  spi_state_e state;
  logic [7:0] div_q;
  logic [7:0] cnt;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic       ctrl_cs;
  logic       txovf;
  logic       rxovf;

  logic       tx_full, tx_empty;
  logic       rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic       data_wr, data_rd, stat_wr;
  logic       tx_pop, rx_pop, rx_push;
  logic [7:0] status;

  assign data_wr = reg_wr && (reg_sel == REG_DATA);
  assign data_rd = reg_rd && (reg_sel == REG_DATA);
  assign stat_wr = reg_wr && (reg_sel == REG_STATUS);
  assign tx_pop  = (state == S_LOAD);
  assign rx_push = (state == S_DONE);
  assign rx_pop  = data_rd && !rx_empty;

  dfb_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .CLKOSC (CLKOSC),
    .RST    (RST),
    .push   (data_wr),
    .pop    (tx_pop),
    .wdata  (reg_wdata),
    .rdata  (tx_head),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  dfb_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .CLKOSC (CLKOSC),
    .RST    (RST),
    .push   (rx_push),
    .pop    (rx_pop),
    .wdata  (shreg),
    .rdata  (rx_head),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  assign busy = (state != S_IDLE) || !tx_empty;

`ifdef DFB_SPI_AUTOCS_EN
  assign spi_cs = (state == S_IDLE);
`else
  assign spi_cs = ctrl_cs;
`endif

  always_comb begin
    status = '0;
    status[ST_BUSY]    = busy;
    status[ST_TXFULL]  = tx_full;
    status[ST_TXEMPTY] = tx_empty;
    status[ST_RXFULL]  = rx_full;
    status[ST_RXEMPTY] = rx_empty;
    status[ST_TXOVF]   = txovf;
    status[ST_RXOVF]   = rxovf;
    status[ST_CS]      = spi_cs;
  end

  always_comb begin
    reg_rdata = 8'hFF;
    unique case (reg_sel)
      REG_DATA:   reg_rdata = rx_empty ? 8'hFF : rx_head;
      REG_STATUS: reg_rdata = status;
      REG_DIV:    reg_rdata = div_q;
      REG_CTRL:   reg_rdata = {7'b0, ctrl_cs};
      default:    reg_rdata = 8'hFF;
    endcase
  end

  // Overflow sets are placed after the clears so a same-cycle event wins.
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      div_q   <= DIV_RESET;
      ctrl_cs <= 1'b1;
      txovf   <= 1'b0;
      rxovf   <= 1'b0;
    end else begin
      if (reg_wr && (reg_sel == REG_DIV))  div_q   <= reg_wdata;
      if (reg_wr && (reg_sel == REG_CTRL)) ctrl_cs <= reg_wdata[0];
      if (stat_wr && reg_wdata[ST_TXOVF])  txovf   <= 1'b0;
      if (stat_wr && reg_wdata[ST_RXOVF])  rxovf   <= 1'b0;
      if (data_wr && tx_full && !tx_pop)   txovf   <= 1'b1;
      if (rx_push && rx_full && !rx_pop)   rxovf   <= 1'b1;
    end
  end

  // MISO shifts in on the rising edge; the next MOSI bit leaves on the fall.
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!tx_empty || data_wr) state <= S_LOAD;
        end
        S_LOAD: begin
          shreg    <= tx_head;
          spi_mosi <= tx_head[7];
          bitcnt   <= '0;
          cnt      <= div_q;
          state    <= S_LO;
        end
        S_LO: begin
          if (cnt == '0) begin
            spi_clk <= 1'b1;
            shreg   <= {shreg[6:0], spi_miso};
            cnt     <= div_q;
            state   <= S_HI;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HI: begin
          if (cnt == '0) begin
            spi_clk <= 1'b0;
            cnt     <= div_q;
            if (bitcnt == 3'd7) begin
              state <= S_DONE;
            end else begin
              bitcnt   <= bitcnt + 3'd1;
              spi_mosi <= shreg[7];
              state    <= S_LO;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (!tx_empty) begin
            state <= S_LOAD;
          end else begin
            state    <= S_IDLE;
            spi_mosi <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfb_spi_sequencer.sv
// tb_dfb_spi_sequencer: randomized register traffic against a byte-level
// timing model of the SPI sequencer, plus directed corner cases.
module tb_dfb_spi_sequencer;

  localparam int DEPTH = 4;

  logic       CLKOSC = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] reg_sel = 2'd0;
  logic       reg_wr = 1'b0;
  logic       reg_rd = 1'b0;
  logic [7:0] reg_wdata = 8'd0;
  logic [7:0] reg_rdata;
  logic       spi_clk, spi_mosi, spi_miso, spi_cs, busy;
  logic       inv = 1'b0;

  assign spi_miso = spi_mosi ^ inv;

  dfb_spi_sequencer #(.FIFO_DEPTH(DEPTH), .DIV_RESET(8'd49)) dut (
    .CLKOSC    (CLKOSC),
    .RST       (RST),
    .reg_sel   (reg_sel),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_cs    (spi_cs),
    .busy      (busy)
  );

  always #5 CLKOSC = ~CLKOSC;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: a byte occupies cycles L (load) .. D (done); the bit phases
  // in between follow from the half-period length div+1.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         active;
  int         L, D, cyc, div;
  logic [7:0] cur;
  bit         txovf_m, rxovf_m, ctrl_m;
  logic [7:0] last_rdata;
  logic       last_busy, last_sck;

  function automatic void model_reset();
    txq.delete();
    rxq.delete();
    active  = 0;
    txovf_m = 0;
    rxovf_m = 0;
    ctrl_m  = 1;
    div     = 49;
  endfunction

  function automatic logic m_busy();
    return active || (txq.size() != 0);
  endfunction

  function automatic logic m_cs();
`ifdef DFB_SPI_AUTOCS_EN
    return !active;
`else
    return ctrl_m;
`endif
  endfunction

  function automatic logic [7:0] m_status();
    return {m_busy(), txq.size() == DEPTH, txq.size() == 0,
            rxq.size() == DEPTH, rxq.size() == 0,
            txovf_m, rxovf_m, m_cs()};
  endfunction

  function automatic logic [7:0] m_rdata(input logic [1:0] sel);
    case (sel)
      2'd0:    return (rxq.size() != 0) ? rxq[0] : 8'hFF;
      2'd1:    return m_status();
      2'd2:    return div[7:0];
      default: return {7'b0, ctrl_m};
    endcase
  endfunction

  function automatic bit in_bits();
    return active && (cyc > L) && (cyc < D);
  endfunction

  function automatic int half_idx();
    return (cyc - L - 1) / (div + 1);
  endfunction

  function automatic void start_byte(input int at);
    active = 1;
    L = at;
    D = at + 16 * (div + 1) + 1;
  endfunction

  function automatic void model_step(input logic wr, input logic rd,
                                     input logic [1:0] sel,
                                     input logic [7:0] wd);
    bit was_active;
    was_active = active;
    if (wr && sel == 2'd1) begin
      if (wd[2]) txovf_m = 0;
      if (wd[1]) rxovf_m = 0;
    end
    if (wr && sel == 2'd3) ctrl_m = wd[0];
    if (wr && sel == 2'd2) div = int'(wd);
    if (rd && sel == 2'd0 && rxq.size() != 0) void'(rxq.pop_front());
    if (active && cyc == L) cur = txq.pop_front();
    if (active && cyc == D) begin
      if (rxq.size() < DEPTH) rxq.push_back(cur ^ {8{inv}});
      else rxovf_m = 1;
      if (txq.size() != 0) start_byte(cyc + 1);
      else active = 0;
    end
    if (wr && sel == 2'd0) begin
      if (txq.size() < DEPTH) txq.push_back(wd);
      else txovf_m = 1;
    end
    if (!was_active && txq.size() != 0) start_byte(cyc + 1);
  endfunction

  // One CLKOSC cycle: drive, check all outputs, then advance the model.
  task automatic cyc_op(input logic wr, input logic rd,
                        input logic [1:0] sel, input logic [7:0] wd);
    reg_wr = wr;
    reg_rd = rd;
    reg_sel = sel;
    reg_wdata = wd;
    #1;
    last_rdata = reg_rdata;
    last_busy = busy;
    last_sck = spi_clk;
    chk("busy", busy, m_busy());
    chk("cs", spi_cs, m_cs());
    chk("rdata", reg_rdata, m_rdata(sel));
    chk("sck", spi_clk, in_bits() && half_idx() % 2 == 1);
    if (!active) chk("mosi_idle", spi_mosi, 1'b1);
    else if (in_bits()) chk("mosi", spi_mosi, cur_bit());
    @(posedge CLKOSC);
    model_step(wr, rd, sel, wd);
    cyc++;
    @(negedge CLKOSC);
    reg_wr = 1'b0;
    reg_rd = 1'b0;
  endtask

  function automatic logic cur_bit();
    logic [7:0] b;
    b = txq.size() != 0 && cyc == L ? txq[0] : cur;
    return b[7 - half_idx() / 2];
  endfunction

  task automatic drain();
    int n = 0;
    while ((active || txq.size() != 0) && n < 20000) begin
      cyc_op(1'b0, 1'b0, 2'd1, 8'd0);
      n++;
    end
    chk("drain_timeout", n >= 20000, 1'b0);
  endtask

  task automatic flush_rx();
    while (rxq.size() != 0) cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
  endtask

  task automatic rand_block(input int dv, input logic iv, input int n);
    int r;
    drain();
    cyc_op(1'b1, 1'b0, 2'd2, dv[7:0]);
    inv = iv;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      cyc_op(1'b1, 1'b0, 2'd0, 8'($urandom));
      else if (r < 35) cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
      else if (r < 45) cyc_op(1'b0, 1'b1, 2'd1, 8'd0);
      else if (r < 50) cyc_op(1'b1, 1'b0, 2'd1, 8'($urandom));
      else if (r < 53) cyc_op(1'b1, 1'b0, 2'd3, 8'($urandom));
      else             cyc_op(1'b0, 1'b0, 2'($urandom), 8'd0);
    end
    drain();
    flush_rx();
    cyc_op(1'b1, 1'b0, 2'd1, 8'h06);
    inv = 1'b0;
  endtask

  logic [7:0] bytes5 [5];
  int busy_n, pulses, n;
  logic prev_sck;

  initial begin
    model_reset();
    cyc = 0;
    @(negedge CLKOSC);
    @(negedge CLKOSC);
    RST = 1'b0;

    // reset state
    cyc_op(1'b0, 1'b1, 2'd1, 8'd0);
    chk("rst_status", last_rdata, 8'h29);
    cyc_op(1'b0, 1'b0, 2'd2, 8'd0);
    chk("rst_div", last_rdata, 8'd49);
    chk("rst_mosi", spi_mosi, 1'b1);
    chk("rst_sck", spi_clk, 1'b0);
    cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
    chk("rst_data", last_rdata, 8'hFF);

    // DIV=0 loopback single byte
    cyc_op(1'b1, 1'b0, 2'd2, 8'd0);
    cyc_op(1'b1, 1'b0, 2'd0, 8'hA5);
    busy_n = 0;
    pulses = 0;
    prev_sck = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc_op(1'b0, 1'b0, 2'd1, 8'd0);
      if (last_busy) busy_n++;
      if (last_sck && !prev_sck) pulses++;
      prev_sck = last_sck;
    end
    chk("a5_busy_cycles", 16'(busy_n), 16'd18);
    chk("a5_pulses", 16'(pulses), 16'd8);
    cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
    chk("a5_rx", last_rdata, 8'hA5);
    cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
    chk("a5_rx_empty", last_rdata, 8'hFF);

    // DIV=1, five bytes with no reads: RX overflows
    cyc_op(1'b1, 1'b0, 2'd2, 8'd1);
    for (int i = 0; i < 5; i++) begin
      bytes5[i] = 8'($urandom);
      cyc_op(1'b1, 1'b0, 2'd0, bytes5[i]);
    end
    cyc_op(1'b0, 1'b1, 2'd1, 8'd0);
    chk("five_txovf", last_rdata[2], 1'b0);
    drain();
    cyc_op(1'b0, 1'b1, 2'd1, 8'd0);
    chk("five_rxovf", last_rdata[1], 1'b1);
    chk("five_rxfull", last_rdata[4], 1'b1);
    cyc_op(1'b1, 1'b0, 2'd1, 8'h02);
    cyc_op(1'b0, 1'b1, 2'd1, 8'd0);
    chk("rxovf_clr", last_rdata[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
      chk("five_rx", last_rdata, bytes5[i]);
    end

    // DIV=49, six back-to-back writes: one dropped
    cyc_op(1'b1, 1'b0, 2'd2, 8'd49);
    for (int i = 0; i < 6; i++) cyc_op(1'b1, 1'b0, 2'd0, 8'(8'h30 + i));
    cyc_op(1'b0, 1'b1, 2'd1, 8'd0);
    chk("six_txovf", last_rdata[2], 1'b1);
    chk("six_txfull", last_rdata[6], 1'b1);
    drain();
    flush_rx();
    cyc_op(1'b1, 1'b0, 2'd1, 8'h06);

    // CS control through CTRL
    cyc_op(1'b1, 1'b0, 2'd3, 8'h00);
    cyc_op(1'b0, 1'b0, 2'd3, 8'd0);
    cyc_op(1'b1, 1'b0, 2'd3, 8'h01);

    // two queued bytes back to back
    cyc_op(1'b1, 1'b0, 2'd2, 8'd0);
    cyc_op(1'b1, 1'b0, 2'd0, 8'h3C);
    cyc_op(1'b1, 1'b0, 2'd0, 8'hC3);
    drain();
    cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
    chk("pair_rx0", last_rdata, 8'h3C);
    cyc_op(1'b0, 1'b1, 2'd0, 8'd0);
    chk("pair_rx1", last_rdata, 8'hC3);

    // reset during bit 3
    cyc_op(1'b1, 1'b0, 2'd2, 8'd3);
    cyc_op(1'b1, 1'b0, 2'd0, 8'h5A);
    n = 0;
    while (cyc != L + 1 + 7 * (div + 1) + 1 && n < 200) begin
      cyc_op(1'b0, 1'b0, 2'd1, 8'd0);
      n++;
    end
    chk("rst_wait_timeout", n >= 200, 1'b0);
    #1;
    chk("pre_rst_sck", spi_clk, 1'b1);
    RST = 1'b1;
    #1;
    chk("midrst_sck", spi_clk, 1'b0);
    chk("midrst_mosi", spi_mosi, 1'b1);
    chk("midrst_cs", spi_cs, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    model_reset();
    @(posedge CLKOSC);
    @(negedge CLKOSC);
    RST = 1'b0;
    cyc_op(1'b0, 1'b1, 2'd1, 8'd0);
    chk("post_rst_status", last_rdata, 8'h29);

    // randomized traffic
    rand_block(0, 1'b0, 300);
    rand_block(1, 1'b1, 300);
    rand_block(2, 1'b0, 300);
    rand_block(3, 1'b1, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
